fp_add_arbiter: RTL and testbench
=================================

// Module: fp_add_arbiter
// PURPOSE
//  Shares one combinational IEEE-754 single-precision adder between NUM_REQ requesters.
//  Round-robin grant, at most one add issued per cycle. The adder's sum is registered into
//  a per-requester response slot that is held until the requester accepts it.
//  Sits between the requester-side valid/ready interfaces and the shared adder datapath.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..8)
//  CNT_W    16  width of the issued-operation counter
// PORTS
//  clk          in   1            single clock, all state updates on rising edge
//  rst          in   1            synchronous, active-high reset
//  req_valid    in   NUM_REQ      requester i holds an operand pair
//  req_a        in   32*NUM_REQ   operand A of requester i, bits [32i+31:32i]
//  req_b        in   32*NUM_REQ   operand B of requester i, same packing
//  req_ready    out  NUM_REQ      one-hot grant; pair accepted when req_valid[i]&req_ready[i]
//  rsp_valid    out  NUM_REQ      response slot i full
//  rsp_data     out  32*NUM_REQ   registered sum for requester i
//  rsp_ready    in   NUM_REQ      requester i consumes slot i
//  add_a        out  32           operand A to the shared adder
//  add_b        out  32           operand B to the shared adder
//  add_sum      in   32           combinational adder result for add_a+add_b
//  issue_cnt    out  CNT_W        number of issued adds, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Reset: rsp_valid=0, rsp_data=0, rr_ptr=0, issue_cnt=0. Pending responses are dropped.
//    req_ready=0 while rst=1. Reset mid-operation discards any in-flight grant.
//  - Eligibility: elig[i] = req_valid[i] & ~rsp_valid[i].
//    A full slot blocks its requester even when rsp_ready[i]=1 in the same cycle,
//    so a requester issues at most one add per two cycles.
//  - Arbitration (combinational): the first eligible index scanning rr_ptr, rr_ptr+1, ...
//    mod NUM_REQ gets req_ready. At most one bit of req_ready is set.
//    req_ready depends on req_valid. Requesters must not make req_valid depend on req_ready.
//  - Operand mux: add_a/add_b = req_a/req_b of the granted index; 32'h0 when no grant.
//  - On a grant g at edge t:
//    - rsp_data[g] <= add_sum, rsp_valid[g] <= 1
//    - rr_ptr <= (g+1) mod NUM_REQ
//    - issue_cnt <= issue_cnt+1
//  - No grant: rr_ptr and issue_cnt hold.
//  - Latency: accept cycle -> rsp_valid high the next cycle (1 cycle). Throughput is 1 add/cycle
//    across requesters.
//  - Response: slot i clears when rsp_valid[i]&rsp_ready[i]. rsp_data[i] holds until the
//    next grant to i. Slot clear and new grant cannot coincide for the same i (see eligibility).
//  - Fairness: a continuously eligible requester is granted within NUM_REQ cycles.
//  - issue_cnt wraps from all-ones to 0 with no flag.
//  - Operands and sums pass unmodified. Special-value handling is owned by the adder.
// STRUCTURE
//  - Shared package: FP_W=32 and the packing helper for the 32*NUM_REQ buses.
//  - One sub-module: rr_arbiter (NUM_REQ) with inputs elig and ptr and outputs gnt one-hot,
//    gnt_idx, gnt_any.
//  - Top level holds rr_ptr, response slots, operand mux and issue_cnt.
// TESTING
//  1 Single request: req0 A=3F800000 B=40000000 -> req_ready[0] same cycle;
//    next cycle rsp_valid[0]=1, rsp_data[0]=40400000 (1.0+2.0); issue_cnt=1.
//  2 All four valid, rsp_ready all 1 -> grants 0,1,2,3,0... in order; rr_ptr wraps 3->0;
//    no requester waits more than 4 cycles.
//  3 Backpressure: req1 granted (3FC00000+3FC00000), rsp_ready[1]=0 for 5 cycles ->
//    rsp_data[1]=40400000 stable; req_ready[1] stays 0 while req1 re-presents; others still granted.
//  4 Reset mid-operation: slots 0 and 2 full, assert rst 1 cycle -> all rsp_valid=0,
//    issue_cnt=0; next grant goes to lowest eligible index starting at 0.
//  5 Idle: no req_valid -> add_a=add_b=0, req_ready=0, issue_cnt and rr_ptr unchanged.
//  6 Counter wrap: preload to 2^CNT_W-1 via 65535 issues -> next issue gives issue_cnt=0.

Source files
------------

// File: rtl/fp_add_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fp_add_arbiter_pkg
// Shared definitions for the shared single-precision adder arbiter:
//   FP_W        operand / sum width
//   MAX_REQ     largest supported requester count, sets the padded bus width
//   rsp_slot_t  one response slot (full flag + held sum)
//   lane_get    extracts lane idx from a packed 32-bit-per-lane bus
// -----------------------------------------------------------------------------
package fp_add_arbiter_pkg;

  localparam int FP_W    = 32;
  localparam int MAX_REQ = 8;
  localparam int PACK_W  = MAX_REQ * FP_W;

  typedef logic [FP_W-1:0] fp_word_t;

  typedef struct packed {
    logic     full;
    fp_word_t data;
  } rsp_slot_t;

  // Lane idx of a bus packed as {lane[MAX_REQ-1], ..., lane[1], lane[0]}.
  // Callers zero-extend their NUM_REQ-lane bus to PACK_W first.
  function automatic fp_word_t lane_get(input logic [PACK_W-1:0] bus, input logic [2:0] idx);
    logic [PACK_W-1:0] shifted;
    shifted = bus >> (idx * FP_W);
    return shifted[FP_W-1:0];
  endfunction

endpackage

// File: rtl/fp_add_arbiter_if.sv
// -----------------------------------------------------------------------------
// fp_add_arbiter_if
// Bundles the requester handshakes, response slots, shared-adder datapath and
// issue counter of fp_add_arbiter.
//   slave  : arbiter side (drives req_ready, rsp_*, add_a/add_b, issue_cnt)
//   master : requesters + adder side (drives req_*, rsp_ready, add_sum)
// -----------------------------------------------------------------------------
interface fp_add_arbiter_if
  import fp_add_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16
);

  logic [NUM_REQ-1:0]      req_valid;
  logic [FP_W*NUM_REQ-1:0] req_a;
  logic [FP_W*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ-1:0]      rsp_valid;
  logic [FP_W*NUM_REQ-1:0] rsp_data;
  logic [NUM_REQ-1:0]      rsp_ready;
  logic [FP_W-1:0]         add_a;
  logic [FP_W-1:0]         add_b;
  logic [FP_W-1:0]         add_sum;
  logic [CNT_W-1:0]        issue_cnt;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, add_sum,
    output req_ready, rsp_valid, rsp_data, add_a, add_b, issue_cnt
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, add_sum,
    input  req_ready, rsp_valid, rsp_data, add_a, add_b, issue_cnt
  );

endinterface

// File: rtl/fp_add_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// fp_add_arbiter_rr_arbiter
// Combinational round-robin pick: the first set bit of elig_i scanning
// ptr_i, ptr_i+1, ... modulo NUM_REQ.
//   elig_i     eligible requesters
//   ptr_i      highest-priority index this cycle (< NUM_REQ)
//   gnt_o      one-hot grant
//   gnt_idx_o  index of the granted requester (0 when none)
//   gnt_any_o  a grant was made
// -----------------------------------------------------------------------------
module fp_add_arbiter_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] elig_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_any_o
);

  // Priority scan from the farthest offset down to offset 0, so the last
  // eligible hit (the nearest one to ptr_i) is the one that sticks.
  always_comb begin : scan
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    gnt_o     = {NUM_REQ{1'b0}};
    gnt_idx_o = {IDX_W{1'b0}};
    gnt_any_o = 1'b0;
    sum       = {(IDX_W+1){1'b0}};
    idx       = {IDX_W{1'b0}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum       = {1'b0, ptr_i} + (IDX_W+1)'(k);
      sum       = (sum >= (IDX_W+1)'(NUM_REQ)) ? (sum - (IDX_W+1)'(NUM_REQ)) : sum;
      idx       = sum[IDX_W-1:0];
      gnt_idx_o = elig_i[idx] ? idx : gnt_idx_o;
      gnt_any_o = gnt_any_o | elig_i[idx];
    end
    if (gnt_any_o) begin
      gnt_o[gnt_idx_o] = 1'b1;
    end else begin
      gnt_o = {NUM_REQ{1'b0}};
    end
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// -----------------------------------------------------------------------------
// fp_add_arbiter
// Shares one combinational single-precision adder between NUM_REQ requesters.
// One add per cycle, round-robin; each sum lands in a per-requester response
// slot that is held until the requester takes it.
//   clk   rising-edge clock
//   rst   synchronous active-high reset (drops pending responses, no grant)
//   bus   fp_add_arbiter_if.slave: req_valid/req_a/req_b/req_ready,
//         rsp_valid/rsp_data/rsp_ready, add_a/add_b/add_sum, issue_cnt
// -----------------------------------------------------------------------------
module fp_add_arbiter
  import fp_add_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  fp_add_arbiter_if.slave     bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] slot_full_s;
  logic [NUM_REQ-1:0] elig_s;
  logic [NUM_REQ-1:0] gnt_raw_s;
  logic [NUM_REQ-1:0] gnt_s;
  logic [IDX_W-1:0]   gnt_idx_s;
  logic               gnt_any_raw_s;
  logic               gnt_any_s;
  logic [PACK_W-1:0]  req_a_pad_s;
  logic [PACK_W-1:0]  req_b_pad_s;

  logic [IDX_W-1:0]   rr_ptr_q,    rr_ptr_d;
  logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
  rsp_slot_t          slot_q [NUM_REQ];
  rsp_slot_t          slot_d [NUM_REQ];

  // Full flags as a vector for the eligibility mask.
  always_comb begin
    slot_full_s = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      slot_full_s[i] = slot_q[i].full;
    end
  end

  // A full slot blocks its requester even if it is being drained this cycle,
  // so a slot never clears and refills on the same edge.
  assign elig_s = bus.req_valid & ~slot_full_s;

  fp_add_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .elig_i    (elig_s),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt_raw_s),
    .gnt_idx_o (gnt_idx_s),
    .gnt_any_o (gnt_any_raw_s)
  );

  // No grant may be presented while reset is held.
  assign gnt_any_s     = gnt_any_raw_s & ~rst;
  assign gnt_s         = rst ? {NUM_REQ{1'b0}} : gnt_raw_s;
  assign bus.req_ready = gnt_s;

  assign req_a_pad_s = PACK_W'(bus.req_a);
  assign req_b_pad_s = PACK_W'(bus.req_b);

  // Operand mux towards the shared adder; zero when idle.
  always_comb begin
    bus.add_a = 32'h0000_0000;
    bus.add_b = 32'h0000_0000;
    if (gnt_any_s) begin
      bus.add_a = lane_get(req_a_pad_s, 3'(gnt_idx_s));
      bus.add_b = lane_get(req_b_pad_s, 3'(gnt_idx_s));
    end else begin
      bus.add_a = 32'h0000_0000;
      bus.add_b = 32'h0000_0000;
    end
  end

  // Next state: drain accepted responses, capture the granted sum, advance
  // the pointer past the winner and count the issue.
  always_comb begin
    slot_d      = slot_q;
    rr_ptr_d    = rr_ptr_q;
    issue_cnt_d = issue_cnt_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (slot_q[i].full && bus.rsp_ready[i]) begin
        slot_d[i].full = 1'b0;
      end else begin
        slot_d[i].full = slot_q[i].full;
      end
    end
    if (gnt_any_s) begin
      slot_d[gnt_idx_s].full = 1'b1;
      slot_d[gnt_idx_s].data = bus.add_sum;
      rr_ptr_d    = (gnt_idx_s == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}} : (gnt_idx_s + IDX_W'(1));
      issue_cnt_d = issue_cnt_q + CNT_W'(1);
    end else begin
      rr_ptr_d    = rr_ptr_q;
      issue_cnt_d = issue_cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= {IDX_W{1'b0}};
      issue_cnt_q <= {CNT_W{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_q[i] <= '{full: 1'b0, data: 32'h0000_0000};
      end
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      issue_cnt_q <= issue_cnt_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  // Response slots and counter straight from registers.
  always_comb begin
    bus.rsp_valid = {NUM_REQ{1'b0}};
    bus.rsp_data  = {(FP_W*NUM_REQ){1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.rsp_valid[i]                = slot_q[i].full;
      bus.rsp_data[i*FP_W +: FP_W]    = slot_q[i].data;
    end
  end

  assign bus.issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fp_add_arbiter
// Self-checking bench: directed scenarios plus randomized traffic against a
// slot/pointer/counter reference model. The bench also plays the adder.
// -----------------------------------------------------------------------------
module tb_fp_add_arbiter;

  localparam int N  = 4;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_add_arbiter_if #(.NUM_REQ(N), .CNT_W(CW)) bus ();

  fp_add_arbiter #(.NUM_REQ(N), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Operand pairs with exactly known single-precision sums.
  localparam logic [31:0] TA [8] = '{32'h3F800000, 32'h3FC00000, 32'h40000000, 32'h3F800000,
                                     32'h3F000000, 32'h40800000, 32'h3F800000, 32'h40400000};
  localparam logic [31:0] TB [8] = '{32'h40000000, 32'h3FC00000, 32'h40000000, 32'h3F800000,
                                     32'h3F000000, 32'h40800000, 32'hBF800000, 32'h3F800000};

  // Stand-in adder: exact sums for the known pairs, otherwise a fixed scramble
  // so that pass-through of arbitrary words is still observable.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000},
      {32'h40000000, 32'h3F800000}: return 32'h40400000;
      {32'h3FC00000, 32'h3FC00000}: return 32'h40400000;
      {32'h40000000, 32'h40000000}: return 32'h40800000;
      {32'h3F800000, 32'h3F800000}: return 32'h40000000;
      {32'h3F000000, 32'h3F000000}: return 32'h3F800000;
      {32'h40800000, 32'h40800000}: return 32'h41000000;
      {32'h3F800000, 32'hBF800000}: return 32'h00000000;
      {32'h40400000, 32'h3F800000}: return 32'h40800000;
      default:                      return {a[31:16] ^ b[15:0], a[15:0] + b[31:16]};
    endcase
  endfunction

  assign bus.add_sum = fadd(bus.add_a, bus.add_b);

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Stimulus state
  logic [N-1:0] in_valid;
  logic [N-1:0] in_rready;
  logic [31:0]  in_a [N];
  logic [31:0]  in_b [N];

  // Reference model state
  bit          m_full [N];
  logic [31:0] m_data [N];
  int          m_ptr;
  int          m_cnt;
  int          m_wait [N];
  int          dut_grant;

  task automatic drive();
    bus.req_valid = in_valid;
    bus.rsp_ready = in_rready;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*32 +: 32] = in_a[i];
      bus.req_b[i*32 +: 32] = in_b[i];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_full[i] = 1'b0;
      m_data[i] = 32'h0;
      m_wait[i] = 0;
    end
    m_ptr = 0;
    m_cnt = 0;
  endtask

  task automatic rand_ops(input int i);
    int k;
    if ($urandom_range(1, 0) == 1) begin
      k = $urandom_range(7, 0);
      in_a[i] = TA[k];
      in_b[i] = TB[k];
    end else begin
      in_a[i] = $urandom;
      in_b[i] = $urandom;
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step(input bit full_chk);
    int g;
    logic [N-1:0] exp_rdy;
    drive();
    @(negedge clk);
    g = -1;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (g < 0 && in_valid[idx] && !m_full[idx]) g = idx;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    dut_grant = -1;
    for (int i = 0; i < N; i++) if (bus.req_ready[i]) dut_grant = i;
    check_eq("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    check_eq("issue_cnt", 32'(bus.issue_cnt), 32'(m_cnt));
    if (full_chk) begin
      check_eq("add_a", bus.add_a, (g >= 0) ? in_a[g] : 32'h0);
      check_eq("add_b", bus.add_b, (g >= 0) ? in_b[g] : 32'h0);
      for (int i = 0; i < N; i++) begin
        check_eq("rsp_valid", 32'(bus.rsp_valid[i]), 32'(m_full[i]));
        check_eq("rsp_data", bus.rsp_data[i*32 +: 32], m_data[i]);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!rst && in_valid[i] && !m_full[i]) begin
        if (g == i) begin
          check_eq("fairness", 32'(m_wait[i] < N), 32'd1);
          m_wait[i] = 0;
        end else begin
          m_wait[i]++;
        end
      end else begin
        m_wait[i] = 0;
      end
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < N; i++) if (m_full[i] && in_rready[i]) m_full[i] = 1'b0;
      if (g >= 0) begin
        m_full[g] = 1'b1;
        m_data[g] = fadd(in_a[g], in_b[g]);
        m_ptr     = (g + 1) % N;
        m_cnt     = (m_cnt + 1) % (1 << CW);
      end
    end
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int start;
    int others;
    int cnt_hold;
    int guard;

    // ---------------- reset ----------------
    rst       = 1'b1;
    in_valid  = '0;
    in_rready = '0;
    for (int i = 0; i < N; i++) begin
      in_a[i] = 32'h0;
      in_b[i] = 32'h0;
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check_eq("rst_issue_cnt", 32'(bus.issue_cnt), 32'h0);
    check_eq("rst_rsp_data0", bus.rsp_data[31:0], 32'h0);
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'h0);
    rst = 1'b0;

    // ---------------- 1: single request ----------------
    in_valid = 4'b0001;
    in_a[0]  = 32'h3F800000;
    in_b[0]  = 32'h40000000;
    step(1);
    in_valid = 4'b0000;
    check_eq("t1_rsp_valid0", 32'(bus.rsp_valid[0]), 32'd1);
    check_eq("t1_rsp_data0", bus.rsp_data[31:0], 32'h40400000);
    check_eq("t1_issue_cnt", 32'(bus.issue_cnt), 32'd1);
    in_rready = 4'b1111;
    step(1);
    step(1);

    // ---------------- 2: all requesting, all draining ----------------
    in_valid = 4'b1111;
    for (int i = 0; i < N; i++) rand_ops(i);
    start = m_ptr;
    for (int k = 0; k < 12; k++) begin
      step(1);
      check_eq("t2_order", 32'(dut_grant), 32'((start + k) % N));
    end

    // ---------------- 3: backpressure on requester 1 ----------------
    in_a[1]   = 32'h3FC00000;
    in_b[1]   = 32'h3FC00000;
    in_rready = 4'b1101;
    guard     = 0;
    dut_grant = -1;
    while (dut_grant != 1 && guard < 8) begin
      step(1);
      guard++;
    end
    check_eq("t3_grant1", 32'(dut_grant), 32'd1);
    others = 0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      if (dut_grant >= 0 && dut_grant != 1) others++;
      check_eq("t3_rsp_data1", bus.rsp_data[63:32], 32'h40400000);
      check_eq("t3_rsp_valid1", 32'(bus.rsp_valid[1]), 32'd1);
    end
    check_eq("t3_others", 32'(others), 32'd5);
    in_rready = 4'b1111;
    in_valid  = 4'b0000;
    step(1);
    step(1);

    // ---------------- 4: reset mid-operation ----------------
    in_valid  = 4'b0101;
    in_rready = 4'b0000;
    step(1);
    step(1);
    check_eq("t4_full02", 32'(bus.rsp_valid), 32'h5);
    rst      = 1'b1;
    in_valid = 4'b1110;
    step(1);
    rst = 1'b0;
    check_eq("t4_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check_eq("t4_issue_cnt", 32'(bus.issue_cnt), 32'h0);
    in_valid  = 4'b0110;
    in_rready = 4'b1111;
    step(1);
    check_eq("t4_first_grant", 32'(dut_grant), 32'd1);

    // ---------------- 5: idle ----------------
    in_valid = 4'b0000;
    step(1);
    cnt_hold = m_cnt;
    for (int k = 0; k < 3; k++) begin
      step(1);
      check_eq("t5_add_a", bus.add_a, 32'h0);
      check_eq("t5_add_b", bus.add_b, 32'h0);
    end
    check_eq("t5_issue_cnt", 32'(bus.issue_cnt), 32'(cnt_hold));

    // ---------------- randomized traffic ----------------
    for (int k = 0; k < 400; k++) begin
      in_valid  = N'($urandom);
      in_rready = N'($urandom);
      for (int i = 0; i < N; i++) rand_ops(i);
      rst = ($urandom_range(49, 0) == 0);
      step(1);
    end
    rst = 1'b0;

    // ---------------- 6: counter wrap ----------------
    in_valid  = 4'b1111;
    in_rready = 4'b1111;
    guard     = 0;
    while (m_cnt != (1 << CW) - 1 && guard < 70000) begin
      step(0);
      guard++;
    end
    check_eq("t6_preload", 32'(bus.issue_cnt), 32'h0000FFFF);
    step(1);
    check_eq("t6_wrap", 32'(bus.issue_cnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
